bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
- Sequencer for the sample-capture BRAM. Fills the BRAM with FIR output samples on operator command, flags full, then streams stored samples back out at a consumer-paced rate.
- Owns the write/read address counters and the BRAM write/read enables, which the top level previously built from ad-hoc counters and a separate FSM.
- Sits between the switch/LED interface and the bram instance in top.

Parameters:
- NB_ADDR, 15, width of BRAM write/read address.
- RAM_DEPTH, 32768, number of words captured per run; must satisfy 2 <= RAM_DEPTH <= 2**NB_ADDR.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_capture  input  1  capture command, level from switch; rising edge detected internally.
- i_read  input  1  read-out command, level from switch; rising edge detected internally.
- i_sample_valid  input  1  FIR sample present this cycle.
- i_read_step  input  1  consumer ready for next word.
- o_write_enable  output  1  BRAM write enable.
- o_write_addr  output  NB_ADDR  BRAM write address.
- o_read_enable  output  1  BRAM read enable.
- o_read_addr  output  NB_ADDR  BRAM read address.
- o_read_valid  output  1  BRAM o_data valid this cycle.
- o_full  output  1  capture complete, buffer holds RAM_DEPTH valid words (drives LED).
- o_busy  output  1  high in WRITE or READ.
- o_done  output  1  one-cycle pulse at end of capture and at end of read-out.

Behaviour:
- Reset (async, any state): state=IDLE, both addresses=0, all outputs=0, edge-detect registers=0, so a switch already high at reset release does NOT produce an edge.
- Edge detect: cap_rise = i_capture & ~i_capture_d; rd_rise likewise. Both are registered each cycle.
- Unused switch edges are discarded, not queued.
- States: IDLE, WRITE, FULL, READ (2-bit encoded).
- IDLE:
  - cap_rise -> WRITE, write addr=0.
  - rd_rise ignored (nothing captured).
- WRITE:
  - o_write_enable = i_sample_valid (combinational), o_write_addr = current counter.
  - On each accepted sample the counter increments next cycle.
  - On an accepted sample at addr RAM_DEPTH-1: counter wraps to 0, next state FULL, o_full=1, o_done pulses in the first FULL cycle.
  - Edges ignored in WRITE.
- FULL:
  - o_full=1, enables 0.
  - cap_rise -> WRITE, o_full cleared, write addr=0 (recapture).
  - rd_rise -> READ, read addr=0.
  - Simultaneous cap_rise and rd_rise: capture wins.
- READ:
  - o_read_enable = i_read_step (combinational), o_read_addr = current counter; increments after each accepted step.
  - o_read_valid = o_read_enable delayed one cycle (1-cycle BRAM latency).
  - After the step at addr RAM_DEPTH-1: counter wraps to 0, next state FULL, o_done pulses in the cycle o_read_valid is high for the last word.
  - o_full stays 1 throughout READ (data retained).
  - cap_rise and rd_rise ignored.
- No write and read enable ever asserted in the same cycle.
- Address arithmetic: modulo RAM_DEPTH, never 2**NB_ADDR when RAM_DEPTH is smaller.
- o_busy = (state==WRITE)|(state==READ), registered.

Test Plan:
- RAM_DEPTH=8, NB_ADDR=3. Reset, raise i_capture, i_sample_valid=1 continuous -> write addr 0..7 on 8 consecutive cycles, o_full=1 and o_done one-cycle pulse after addr 7, o_busy falls.
- Capture with i_sample_valid toggling 1,0,1,0 -> o_write_enable mirrors valid, addresses advance only on valid, 8 writes total, no gaps in address sequence.
- From FULL, raise i_read with i_read_step every 3rd cycle -> read addr 0..7, o_read_valid one cycle after each o_read_enable, o_done with last valid, state returns to FULL with o_full=1.
- Hold i_capture high through reset release -> stays IDLE. In FULL, raise i_capture and i_read in the same cycle -> WRITE entered, o_full=0.
- Assert i_reset mid-WRITE at addr 5 -> all outputs 0 immediately (asynchronous); after release, a new cap_rise restarts at addr 0.
- Toggle i_read in IDLE and i_capture during READ -> no state change, no enables asserted.

Source files
------------

// File: rtl/bram_capture_ctrl.sv
// ---------------------------------------------------------------------------
// bram_capture_ctrl
//
// Sequencer for the sample-capture BRAM. An operator switch starts a capture
// that fills RAM_DEPTH words with FIR samples, after which the buffer is
// flagged full. A second switch then streams the stored words back out, one
// word per consumer step. The block owns both address counters and both BRAM
// enables so the top level only wires it to the switches, LEDs and the RAM.
//
// Ports:
//   clock           system clock, everything on the rising edge
//   i_reset         asynchronous active-high reset
//   i_capture       capture switch level (rising edge starts a capture)
//   i_read          read-out switch level (rising edge starts a read-out)
//   i_sample_valid  FIR sample present this cycle
//   i_read_step     consumer ready for the next word
//   o_write_enable  BRAM write enable
//   o_write_addr    BRAM write address
//   o_read_enable   BRAM read enable
//   o_read_addr     BRAM read address
//   o_read_valid    BRAM read data valid (one cycle after o_read_enable)
//   o_full          buffer holds a complete capture (LED)
//   o_busy          capturing or reading out
//   o_done          one-cycle pulse at the end of a capture or a read-out
// ---------------------------------------------------------------------------
module bram_capture_ctrl #(
    parameter int NB_ADDR   = 15,
    parameter int RAM_DEPTH = 32768
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_capture,
    input  logic               i_read,
    input  logic               i_sample_valid,
    input  logic               i_read_step,
    output logic               o_write_enable,
    output logic [NB_ADDR-1:0] o_write_addr,
    output logic               o_read_enable,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic               o_read_valid,
    output logic               o_full,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } state_t;

    // Counters wrap at RAM_DEPTH, which may be smaller than 2**NB_ADDR.
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

    state_t             state;
    state_t             state_next;
    logic [NB_ADDR-1:0] write_addr;
    logic [NB_ADDR-1:0] write_addr_next;
    logic [NB_ADDR-1:0] read_addr;
    logic [NB_ADDR-1:0] read_addr_next;
    logic               write_enable;
    logic               read_enable;
    logic               read_valid;
    logic               done;
    logic               done_next;

    logic               capture_d;
    logic               read_d;
    logic               armed;
    logic               cap_rise;
    logic               rd_rise;

    // Switch edge detection. The delayed copies reset to 0, so a switch that
    // is already high when reset releases would look like an edge on the
    // first clock. 'armed' stays low for that first clock, which lets the
    // delayed copies pick up the real switch level before any edge counts.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            capture_d <= 1'b0;
            read_d    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            capture_d <= i_capture;
            read_d    <= i_read;
            armed     <= 1'b1;
        end
    end

    assign cap_rise = armed & i_capture & ~capture_d;
    assign rd_rise  = armed & i_read & ~read_d;

    // State register together with the address counters, the read-valid
    // delay that matches the one-cycle BRAM latency, and the done pulse.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            write_addr <= '0;
            read_addr  <= '0;
            read_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            write_addr <= write_addr_next;
            read_addr  <= read_addr_next;
            read_valid <= read_enable;
            done       <= done_next;
        end
    end

    // Next-state and enable decode. Edges arriving in WRITE or READ are
    // simply dropped. In FULL a capture request beats a read request so an
    // operator can always restart acquisition. The done pulse is registered,
    // so it lands in the first FULL cycle, which for a read-out is also the
    // cycle in which the last word is valid.
    always_comb begin
        state_next      = state;
        write_addr_next = write_addr;
        read_addr_next  = read_addr;
        done_next       = 1'b0;
        write_enable    = 1'b0;
        read_enable     = 1'b0;

        case (state)
            IDLE: begin
                if (cap_rise) begin
                    state_next      = WRITE;
                    write_addr_next = '0;
                end
            end

            WRITE: begin
                write_enable = i_sample_valid;
                if (i_sample_valid) begin
                    if (write_addr == LAST_ADDR) begin
                        write_addr_next = '0;
                        state_next      = FULL;
                        done_next       = 1'b1;
                    end else begin
                        write_addr_next = write_addr + NB_ADDR'(1);
                    end
                end
            end

            FULL: begin
                if (cap_rise) begin
                    state_next      = WRITE;
                    write_addr_next = '0;
                end else if (rd_rise) begin
                    state_next     = READ;
                    read_addr_next = '0;
                end
            end

            READ: begin
                read_enable = i_read_step;
                if (i_read_step) begin
                    if (read_addr == LAST_ADDR) begin
                        read_addr_next = '0;
                        state_next     = FULL;
                        done_next      = 1'b1;
                    end else begin
                        read_addr_next = read_addr + NB_ADDR'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status flags decode straight from the state register, so they are
    // glitch-free flop outputs. Data stays in the RAM during read-out, hence
    // full remains asserted in READ.
    assign o_write_enable = write_enable;
    assign o_write_addr   = write_addr;
    assign o_read_enable  = read_enable;
    assign o_read_addr    = read_addr;
    assign o_read_valid   = read_valid;
    assign o_full         = (state == FULL) | (state == READ);
    assign o_busy         = (state == WRITE) | (state == READ);
    assign o_done         = done;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_capture_ctrl
//
// Self-checking bench for bram_capture_ctrl with RAM_DEPTH=8, NB_ADDR=3.
// A behavioural model (flags and integer counters) tracks what every output
// must be; a compare process checks all outputs against it on each falling
// edge. Directed sequences add literal expectations and address logs that
// pin the model itself.
// ---------------------------------------------------------------------------
module tb_bram_capture_ctrl;

    localparam int NB_ADDR = 3;
    localparam int DEPTH   = 8;

    logic               clock = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_capture = 1'b0;
    logic               i_read = 1'b0;
    logic               i_sample_valid = 1'b0;
    logic               i_read_step = 1'b0;
    logic               o_write_enable;
    logic [NB_ADDR-1:0] o_write_addr;
    logic               o_read_enable;
    logic [NB_ADDR-1:0] o_read_addr;
    logic               o_read_valid;
    logic               o_full;
    logic               o_busy;
    logic               o_done;

    int tests_run    = 0;
    int tests_failed = 0;

    bit check_en = 1'b0;
    int write_log[$];
    int read_log[$];
    int rvalid_count = 0;

    always #5 clock = ~clock;

    bram_capture_ctrl #(
        .NB_ADDR   (NB_ADDR),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_capture      (i_capture),
        .i_read         (i_read),
        .i_sample_valid (i_sample_valid),
        .i_read_step    (i_read_step),
        .o_write_enable (o_write_enable),
        .o_write_addr   (o_write_addr),
        .o_read_enable  (o_read_enable),
        .o_read_addr    (o_read_addr),
        .o_read_valid   (o_read_valid),
        .o_full         (o_full),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Single comparison point: counts every check and reports any miss.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: is a capture or read-out in progress, is there a
    // complete buffer, and how many words have been moved so far.
    bit m_armed, m_cap_prev, m_rd_prev;
    bit m_writing, m_reading, m_full;
    bit m_valid_q, m_done_q;
    int m_wcnt, m_rcnt;

    wire m_cap_rise = m_armed & i_capture & ~m_cap_prev;
    wire m_rd_rise  = m_armed & i_read & ~m_rd_prev;

    always @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            m_armed    <= 1'b0;
            m_cap_prev <= 1'b0;
            m_rd_prev  <= 1'b0;
            m_writing  <= 1'b0;
            m_reading  <= 1'b0;
            m_full     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_done_q   <= 1'b0;
            m_wcnt     <= 0;
            m_rcnt     <= 0;
        end else begin
            m_armed    <= 1'b1;
            m_cap_prev <= i_capture;
            m_rd_prev  <= i_read;
            m_valid_q  <= m_reading & i_read_step;
            m_done_q   <= 1'b0;
            if (m_writing) begin
                if (i_sample_valid) begin
                    if (m_wcnt + 1 == DEPTH) begin
                        m_writing <= 1'b0;
                        m_full    <= 1'b1;
                        m_done_q  <= 1'b1;
                    end
                    m_wcnt <= (m_wcnt + 1) % DEPTH;
                end
            end else if (m_reading) begin
                if (i_read_step) begin
                    if (m_rcnt + 1 == DEPTH) begin
                        m_reading <= 1'b0;
                        m_done_q  <= 1'b1;
                    end
                    m_rcnt <= (m_rcnt + 1) % DEPTH;
                end
            end else if (m_cap_rise) begin
                m_writing <= 1'b1;
                m_full    <= 1'b0;
                m_wcnt    <= 0;
            end else if (m_rd_rise && m_full) begin
                m_reading <= 1'b1;
                m_rcnt    <= 0;
            end
        end
    end

    // Compare every output against the model on each falling edge, and log
    // the addresses actually presented to the RAM.
    always @(negedge clock) begin
        if (check_en) begin
            check_output("write_enable", o_write_enable, m_writing & i_sample_valid);
            check_output("write_addr", o_write_addr, m_wcnt);
            check_output("read_enable", o_read_enable, m_reading & i_read_step);
            check_output("read_addr", o_read_addr, m_rcnt);
            check_output("read_valid", o_read_valid, m_valid_q);
            check_output("full", o_full, m_full);
            check_output("busy", o_busy, m_writing | m_reading);
            check_output("done", o_done, m_done_q);
            check_output("exclusive_enables", o_write_enable & o_read_enable, 0);
            if (o_write_enable === 1'b1) write_log.push_back(int'(o_write_addr));
            if (o_read_enable === 1'b1) read_log.push_back(int'(o_read_addr));
            if (o_read_valid === 1'b1) rvalid_count++;
        end
    end

    // Inputs change just after the rising edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Literal checks happen just after the falling edge.
    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input bit cap, input bit rd, input bit valid, input bit step);
        i_capture      = cap;
        i_read         = rd;
        i_sample_valid = valid;
        i_read_step    = step;
    endtask

    task automatic check_log(input string name, input int log_q[$]);
        check_output({name, "_count"}, log_q.size(), DEPTH);
        for (int i = 0; i < log_q.size() && i < DEPTH; i++)
            check_output({name, "_seq"}, log_q[i], i);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_en = 1'b1;
        apply_stimulus(0, 0, 0, 0);

        // Reset state
        mid();
        check_output("reset_busy", o_busy, 0);
        check_output("reset_full", o_full, 0);
        check_output("reset_write_addr", o_write_addr, 0);
        check_output("reset_done", o_done, 0);
        cycle();
        i_reset = 1'b0;
        cycle();

        // Continuous capture: addresses 0..7 on consecutive cycles
        write_log.delete();
        apply_stimulus(1, 0, 1, 0);
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            mid();
            check_output("cont_write_enable", o_write_enable, 1);
            check_output("cont_write_addr", o_write_addr, i);
            check_output("cont_full_low", o_full, 0);
            cycle();
        end
        mid();
        check_output("cont_full", o_full, 1);
        check_output("cont_done", o_done, 1);
        check_output("cont_busy_fall", o_busy, 0);
        cycle();
        apply_stimulus(0, 0, 0, 0);
        mid();
        check_output("cont_done_one_cycle", o_done, 0);
        check_log("cont_log", write_log);

        // Recapture with toggling sample valid
        cycle();
        write_log.delete();
        apply_stimulus(1, 0, 0, 0);
        cycle();
        for (int k = 0; k < 16; k++) begin
            i_sample_valid = (k % 2 == 0);
            mid();
            check_output("toggle_mirror", o_write_enable, (k < 15) ? i_sample_valid : 1'b0);
            if (k == 15) begin
                check_output("toggle_done", o_done, 1);
                check_output("toggle_full", o_full, 1);
            end
            cycle();
        end
        apply_stimulus(0, 0, 0, 0);
        check_log("toggle_log", write_log);

        // Read-out stepping every third cycle; capture toggled mid-read
        cycle();
        read_log.delete();
        rvalid_count = 0;
        apply_stimulus(0, 1, 0, 0);
        cycle();
        for (int k = 0; k < 26; k++) begin
            i_read_step = (k % 3 == 2);
            if (k == 5) i_capture = 1'b1;
            if (k == 10) i_capture = 1'b0;
            mid();
            check_output("read_full_held", o_full, 1);
            if (k < 24) check_output("read_busy", o_busy, 1);
            if (k == 24) begin
                check_output("read_last_valid", o_read_valid, 1);
                check_output("read_done", o_done, 1);
                check_output("read_back_full", o_busy, 0);
            end
            cycle();
        end
        apply_stimulus(0, 0, 0, 0);
        check_log("read_log", read_log);
        check_output("read_valid_count", rvalid_count, DEPTH);

        // Capture switch held high through reset release
        i_reset = 1'b1;
        apply_stimulus(1, 0, 1, 0);
        cycle();
        cycle();
        i_reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            mid();
            check_output("held_idle_busy", o_busy, 0);
            check_output("held_idle_we", o_write_enable, 0);
            cycle();
        end

        // Read switch toggled in IDLE is ignored
        for (int j = 0; j < 6; j++) begin
            apply_stimulus(1, j % 2, 1, 1);
            mid();
            check_output("idle_read_re", o_read_enable, 0);
            check_output("idle_read_busy", o_busy, 0);
            cycle();
        end
        apply_stimulus(0, 0, 1, 0);
        cycle();
        i_capture = 1'b1;
        cycle();
        mid();
        check_output("recap_busy", o_busy, 1);
        repeat (8) cycle();
        mid();
        check_output("recap_full", o_full, 1);

        // Simultaneous capture and read edges in FULL: capture wins
        cycle();
        apply_stimulus(0, 0, 0, 0);
        cycle();
        apply_stimulus(1, 1, 0, 0);
        cycle();
        mid();
        check_output("both_busy", o_busy, 1);
        check_output("both_full_clear", o_full, 0);
        check_output("both_no_read", o_read_enable, 0);
        cycle();
        i_sample_valid = 1'b1;
        repeat (8) cycle();
        mid();
        check_output("both_refill_full", o_full, 1);
        cycle();
        apply_stimulus(0, 0, 0, 0);

        // Asynchronous reset in the middle of a capture
        cycle();
        apply_stimulus(1, 0, 1, 0);
        cycle();
        repeat (5) cycle();
        mid();
        check_output("pre_reset_addr", o_write_addr, 5);
        i_reset = 1'b1;
        #1;
        check_output("async_we", o_write_enable, 0);
        check_output("async_write_addr", o_write_addr, 0);
        check_output("async_read_addr", o_read_addr, 0);
        check_output("async_read_valid", o_read_valid, 0);
        check_output("async_full", o_full, 0);
        check_output("async_busy", o_busy, 0);
        check_output("async_done", o_done, 0);
        cycle();
        cycle();
        i_reset = 1'b0;
        apply_stimulus(0, 0, 1, 0);
        cycle();
        i_capture = 1'b1;
        cycle();
        mid();
        check_output("restart_we", o_write_enable, 1);
        check_output("restart_addr0", o_write_addr, 0);
        cycle();
        mid();
        check_output("restart_addr1", o_write_addr, 1);
        repeat (10) cycle();
        apply_stimulus(0, 0, 0, 0);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
